serial_adder_8_bit: RTL and testbench
=====================================

// Module: serial_adder_8_bit
// PURPOSE
//   Bit-serial ripple-carry adder: s = x + y + cin, processed one bit per clock, LSB first.
//   One 1-bit full-adder cell plus a carry flip-flop replaces the WIDTH-cell ripple chain.
//   Addition counterpart to the parallel ripple-borrow subtractor in the arithmetic library.
//   Used where area matters more than latency; start/busy/done handshake to a controller.
// PARAMETERS
//   WIDTH   8   operand and result width in bits (>= 2)
// PORTS
//   clk     in   1      single clock, all state updates on rising edge
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled on a rising edge only while busy=0
//   x       in   WIDTH  augend; captured on the edge where start is accepted
//   y       in   WIDTH  addend; captured with x
//   cin     in   1      carry-in; captured with x, loads the carry flip-flop
//   busy    out  1      1 while the operation is in progress (state RUN)
//   done    out  1      one-cycle pulse: s/cout hold the new result
//   s       out  WIDTH  result register, updated only on completion
//   cout    out  1      final carry-out, updated together with s
// BEHAVIOUR
//   Reset (rst_n=0, any time, async): state=IDLE; busy=0, done=0, s=0, cout=0;
//     operand shift registers, carry FF, bit counter and partial sum cleared.
//   States: IDLE, RUN, DONE.
//   IDLE: start=1 at edge E0 -> latch x, y into shift regs, carry<=cin, cnt<=0, go RUN.
//   RUN (busy=1): each edge: sum bit = xr[0]^yr[0]^carry;
//     carry <= xr[0]&yr[0] | xr[0]&carry | yr[0]&carry; shift xr, yr right;
//     sum bit shifted into MSB of partial-sum reg; cnt++.
//     Edge processing bit WIDTH-1 (edge E0+WIDTH): s <= full partial sum,
//     cout <= final carry, go DONE.
//   DONE: done=1 for exactly one cycle (between edges E0+WIDTH and E0+WIDTH+1), busy=0.
//     start=1 here is accepted like IDLE (back-to-back op, go RUN); else go IDLE.
//   Latency: done high WIDTH cycles after start accepted; throughput 1 op per WIDTH+1 cycles.
//   start while busy=1: ignored, operands unchanged, no queueing.
//   s/cout hold the last completed result through IDLE and through the next RUN;
//     they change only on the completion edge.
//   x, y, cin may change freely after the accept edge; they are not resampled.
//   Arithmetic modulo 2^WIDTH in s; cout is the bit WIDTH of x+y+cin (no overflow flag).
//   Reset mid-RUN: operation abandoned, no done pulse, s/cout read 0; next start runs cleanly.
//   done and busy are never both 1.
// TESTING
//   1. x=8'hFF, y=8'h01, cin=0, start pulse -> busy 8 cycles, done pulse, s=8'h00, cout=1.
//   2. x=8'h00, y=8'h00, cin=1 -> s=8'h01, cout=0; x=8'hFF, y=8'hFF, cin=1 -> s=8'hFF, cout=1.
//   3. start held 1 during RUN with changed x,y -> result of first operands only; one done pulse.
//   4. start=1 during done cycle with x=8'h3C, y=8'hC3, cin=0 -> busy next cycle,
//      s=8'h55 held through RUN, then s=8'hFF, cout=0 after 8 more cycles.
//   5. rst_n low at RUN cycle 4 -> busy=0, done=0, s=0, cout=0 immediately; new op after
//      release gives correct sum.
//   6. Random x,y,cin (>=1000 ops, WIDTH=8 and WIDTH=16) vs {cout,s}==x+y+cin model.

Source files
------------

// File: rtl/serial_adder_8_bit_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The controller drives start/x/y/cin and watches busy/done/s/cout.
interface serial_adder_8_bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;

  modport master (output start, x, y, cin, input busy, done, s, cout);
  modport slave  (input start, x, y, cin, output busy, done, s, cout);
endinterface

// File: rtl/serial_adder_8_bit.sv
// Bit-serial ripple-carry adder: one full-adder cell plus a carry flop,
// consuming one operand bit per clock, LSB first.
module serial_adder_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_8_bit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] yr_q, yr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sum_bit, carry_nx;

  always_comb begin
    state_d  = state_q;
    xr_d     = xr_q;
    yr_d     = yr_q;
    psum_d   = psum_q;
    s_d      = s_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    sum_bit  = xr_q[0] ^ yr_q[0] ^ carry_q;
    carry_nx = (xr_q[0] & yr_q[0]) | (xr_q[0] & carry_q) | (yr_q[0] & carry_q);
    case (state_q)
      // DONE accepts a new request exactly like IDLE, giving back-to-back ops.
      IDLE, DONE: begin
        if (bus.start) begin
          xr_d    = bus.x;
          yr_d    = bus.y;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        xr_d    = xr_q >> 1;
        yr_d    = yr_q >> 1;
        carry_d = carry_nx;
        psum_d  = {sum_bit, psum_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          s_d     = psum_d;
          cout_d  = carry_nx;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_8_bit.sv
// Scoreboard bench for the bit-serial adder: 8-bit and 16-bit instances,
// expectations queued on accept and retired on each done pulse.
module tb_serial_adder_8_bit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_8_bit_if #(.WIDTH(8))  b8 ();
  serial_adder_8_bit_if #(.WIDTH(16)) b16 ();

  serial_adder_8_bit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  serial_adder_8_bit #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  int vectors = 0;
  int miscompares = 0;
  logic [8:0]  q8[$];
  logic [16:0] q16[$];

  // Drive one request at a negedge; the following posedge accepts it.
  task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic c);
    b8.start = 1'b1; b8.x = x; b8.y = y; b8.cin = c;
    q8.push_back({1'b0, x} + {1'b0, y} + {8'd0, c});
    @(negedge clk);
    b8.start = 1'b0;
  endtask

  task automatic drive16(input logic [15:0] x, input logic [15:0] y, input logic c);
    b16.start = 1'b1; b16.x = x; b16.y = y; b16.cin = c;
    q16.push_back({1'b0, x} + {1'b0, y} + {16'd0, c});
    @(negedge clk);
    b16.start = 1'b0;
  endtask

  // Returns at the negedge where done is seen, counting busy cycles on the way.
  task automatic wait_done8(output int nbusy, output bit ok);
    nbusy = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (b8.done) begin ok = 1'b1; return; end
      if (b8.busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done16(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (b16.done) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    b8.start = 1'b0; b8.x = '0; b8.y = '0; b8.cin = 1'b0;
    b16.start = 1'b0; b16.x = '0; b16.y = '0; b16.cin = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({b8.busy, b8.done, b8.cout, b8.s} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset8 got busy=%b done=%b cout=%b s=%h want all 0", b8.busy, b8.done, b8.cout, b8.s);
    end
    vectors++;
    if ({b16.busy, b16.done, b16.cout, b16.s} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset16 got busy=%b done=%b cout=%b s=%h want all 0", b16.busy, b16.done, b16.cout, b16.s);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] tx[3] = '{8'hFF, 8'h00, 8'hFF};
    logic [7:0] ty[3] = '{8'h01, 8'h00, 8'hFF};
    logic       tc[3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] exp;
    int nb; bit ok;
    for (int k = 0; k < 3; k++) begin
      drive8(tx[k], ty[k], tc[k]);
      wait_done8(nb, ok);
      exp = q8.pop_front();
      vectors++;
      if (!ok || {b8.cout, b8.s} !== exp) begin
        miscompares++;
        $display("FAIL basic%0d_sum got ok=%b %h want %h", k, ok, {b8.cout, b8.s}, exp);
      end
      vectors++;
      if (nb != 8 || b8.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL basic%0d_latency got busy_cycles=%0d busy_at_done=%b want 8/0", k, nb, b8.busy);
      end
      @(negedge clk);
      vectors++;
      if (b8.done !== 1'b0 || {b8.cout, b8.s} !== exp) begin
        miscompares++;
        $display("FAIL basic%0d_pulse got done=%b %h want 0 %h", k, b8.done, {b8.cout, b8.s}, exp);
      end
    end
  endtask

  task automatic test_start_held;
    logic [8:0] exp;
    int nb; bit ok; int extra;
    b8.start = 1'b1; b8.x = 8'h21; b8.y = 8'h43; b8.cin = 1'b0;
    q8.push_back(9'h064);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      b8.x = 8'($urandom); b8.y = 8'($urandom); b8.cin = 1'($urandom);
    end
    b8.start = 1'b0;
    wait_done8(nb, ok);
    exp = q8.pop_front();
    vectors++;
    if (!ok || {b8.cout, b8.s} !== exp) begin
      miscompares++;
      $display("FAIL held_sum got ok=%b %h want %h", ok, {b8.cout, b8.s}, exp);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (b8.done || b8.busy) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL held_single_done got %0d extra busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp;
    int nb; bit ok; int held_bad;
    drive8(8'h50, 8'h05, 1'b0);
    wait_done8(nb, ok);
    exp = q8.pop_front();
    vectors++;
    if (!ok || {b8.cout, b8.s} !== exp) begin
      miscompares++;
      $display("FAIL b2b_first got ok=%b %h want %h", ok, {b8.cout, b8.s}, exp);
    end
    drive8(8'h3C, 8'hC3, 1'b0);
    vectors++;
    if (b8.busy !== 1'b1 || b8.s !== 8'h55) begin
      miscompares++;
      $display("FAIL b2b_accept got busy=%b s=%h want 1 55", b8.busy, b8.s);
    end
    held_bad = 0;
    for (int i = 0; i < 40 && !b8.done; i++) begin
      if (b8.s !== 8'h55 || b8.cout !== 1'b0) held_bad++;
      @(negedge clk);
    end
    vectors++;
    if (held_bad != 0) begin
      miscompares++;
      $display("FAIL b2b_hold got %0d cycles with s!=55 want 0", held_bad);
    end
    exp = q8.pop_front();
    vectors++;
    if (!b8.done || {b8.cout, b8.s} !== exp) begin
      miscompares++;
      $display("FAIL b2b_second got done=%b %h want 1 %h", b8.done, {b8.cout, b8.s}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic [8:0] exp;
    int nb; bit ok;
    drive8(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({b8.busy, b8.done, b8.cout, b8.s} !== 11'd0) begin
      miscompares++;
      $display("FAIL midrst got busy=%b done=%b cout=%b s=%h want all 0", b8.busy, b8.done, b8.cout, b8.s);
    end
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive8(8'hA5, 8'h5A, 1'b1);
    wait_done8(nb, ok);
    exp = q8.pop_front();
    vectors++;
    if (!ok || {b8.cout, b8.s} !== exp) begin
      miscompares++;
      $display("FAIL midrst_after got ok=%b %h want %h", ok, {b8.cout, b8.s}, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_random8;
    logic [8:0] exp;
    int nb; bit ok;
    for (int k = 0; k < 1000; k++) begin
      drive8(8'($urandom), 8'($urandom), 1'($urandom));
      wait_done8(nb, ok);
      exp = q8.pop_front();
      vectors++;
      if (!ok || {b8.cout, b8.s} !== exp) begin
        miscompares++;
        $display("FAIL rand8_%0d got ok=%b %h want %h", k, ok, {b8.cout, b8.s}, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random16;
    logic [16:0] exp;
    bit ok;
    for (int k = 0; k < 1000; k++) begin
      drive16(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done16(ok);
      exp = q16.pop_front();
      vectors++;
      if (!ok || {b16.cout, b16.s} !== exp) begin
        miscompares++;
        $display("FAIL rand16_%0d got ok=%b %h want %h", k, ok, {b16.cout, b16.s}, exp);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_random8();
    test_random16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
